// File: rtl/text_menu_pkg.sv
// Shared constants and types for the text-editor menu navigation controller:
// PS/2 set-2 scan codes, menu item codes, window encodings and decoded key ids.
package text_menu_pkg;

    // PS/2 set-2 bytes of interest
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    // Text menu items; ITEM_NONE means the user is editing text
    localparam logic [2:0] ITEM_NONE  = 3'd0;
    localparam logic [2:0] ITEM_OPEN  = 3'd1;
    localparam logic [2:0] ITEM_SAVE  = 3'd2;
    localparam logic [2:0] ITEM_EXIT  = 3'd3;
    localparam logic [2:0] ITEM_CAPS  = 3'd4;
    localparam logic [2:0] ITEM_COLOR = 3'd5;
    localparam logic [2:0] ITEM_SIZE  = 3'd6;

    // Command issued when Exit is chosen in the main dialog
    localparam logic [2:0] CMD_DLG_EXIT = 3'd7;

    // window_selector encodings
    localparam logic WIN_TEXT   = 1'b1;
    localparam logic WIN_DIALOG = 1'b0;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_LEFT  = 3'd1,
        KEY_RIGHT = 3'd2,
        KEY_UP    = 3'd3,
        KEY_DOWN  = 3'd4,
        KEY_ENTER = 3'd5,
        KEY_ESC   = 3'd6
    } key_id_t;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_EXT     = 2'd1,
        PS_BRK     = 2'd2,
        PS_EXT_BRK = 2'd3
    } parse_state_t;

    // Next text menu item to the right, wrapping Size back to Open
    function automatic logic [2:0] item_right(input logic [2:0] item);
        return (item == ITEM_SIZE) ? ITEM_OPEN : item + 3'd1;
    endfunction

    // Next text menu item to the left, wrapping Open back to Size
    function automatic logic [2:0] item_left(input logic [2:0] item);
        return (item == ITEM_OPEN) ? ITEM_SIZE : item - 3'd1;
    endfunction

endpackage

// File: rtl/text_menu_ctrl_ps2_key_decoder.sv
// PS/2 scan-code parser: tracks E0/F0 prefixes, discards break codes and
// keypad (un-prefixed) arrows, abandons stale prefixes after a timeout, and
// emits a registered one-cycle key_valid with the decoded key id.
import text_menu_pkg::*;

module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_code,
    output logic       key_valid,
    output key_id_t    key_id
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    parse_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_valid_q, key_valid_d;
    key_id_t          key_id_q, key_id_d;

    // Next-state, timeout and key decode; a byte arriving on the expiry cycle wins
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_id_d    = KEY_NONE;
        if (scan_done_tick) begin
            case (state_q)
                PS_IDLE: begin
                    case (scan_code)
                        SC_EXT:   state_d = PS_EXT;
                        SC_BRK:   state_d = PS_BRK;
                        SC_ENTER: begin key_valid_d = 1'b1; key_id_d = KEY_ENTER; end
                        SC_ESC:   begin key_valid_d = 1'b1; key_id_d = KEY_ESC;   end
                        default:  ;
                    endcase
                end
                PS_EXT: begin
                    state_d = PS_IDLE;
                    case (scan_code)
                        SC_BRK:   state_d = PS_EXT_BRK;
                        SC_LEFT:  begin key_valid_d = 1'b1; key_id_d = KEY_LEFT;  end
                        SC_RIGHT: begin key_valid_d = 1'b1; key_id_d = KEY_RIGHT; end
                        SC_UP:    begin key_valid_d = 1'b1; key_id_d = KEY_UP;    end
                        SC_DOWN:  begin key_valid_d = 1'b1; key_id_d = KEY_DOWN;  end
                        default:  ;
                    endcase
                end
                default: state_d = PS_IDLE;  // break code byte: discard
            endcase
            if (state_d != PS_IDLE) begin
                cnt_d = '0;
            end
        end else if (state_q != PS_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = PS_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Parser state, timeout counter and decoded key registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PS_IDLE;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_id_q    <= KEY_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_id_q    <= key_id_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_id    = key_id_q;

endmodule

// File: rtl/text_menu_ctrl.sv
// Menu navigation controller: turns decoded keys into item/window selection
// for the menu renderer and one-cycle command strobes for the editor core.
import text_menu_pkg::*;

module text_menu_ctrl #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_code,
    output logic [2:0] item_selector,
    output logic       window_selector,
    output logic       cmd_valid,
    output logic [2:0] cmd_code
);

    logic    key_valid;
    key_id_t key_id;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_decoder (
        .clk           (clk),
        .reset         (reset),
        .scan_done_tick(scan_done_tick),
        .scan_code     (scan_code),
        .key_valid     (key_valid),
        .key_id        (key_id)
    );

    logic       win_q, win_d;
    logic [2:0] item_q, item_d;         // text menu item
    logic       dlg_q, dlg_d;           // dialog item (0 = enter editor, 1 = Exit)
    logic [2:0] item_sel_q, item_sel_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [2:0] cmd_code_q, cmd_code_d;

    // Navigation rules for the dialog and the text menu
    always_comb begin
        win_d       = win_q;
        item_d      = item_q;
        dlg_d       = dlg_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        if (key_valid) begin
            if (win_q == WIN_DIALOG) begin
                case (key_id)
                    KEY_LEFT, KEY_RIGHT, KEY_UP, KEY_DOWN: dlg_d = ~dlg_q;
                    KEY_ENTER: begin
                        if (!dlg_q) begin
                            win_d  = WIN_TEXT;
                            item_d = ITEM_NONE;
                        end else begin
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = CMD_DLG_EXIT;
                        end
                    end
                    default: ;
                endcase
            end else if (item_q == ITEM_NONE) begin
                // While editing, only Esc reaches the menu
                if (key_id == KEY_ESC) begin
                    item_d = ITEM_OPEN;
                end
            end else begin
                case (key_id)
                    KEY_RIGHT: item_d = item_right(item_q);
                    KEY_LEFT:  item_d = item_left(item_q);
                    KEY_ESC:   item_d = ITEM_NONE;
                    KEY_ENTER: begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = item_q;
                        item_d      = ITEM_NONE;
                        if (item_q == ITEM_EXIT) begin
                            win_d = WIN_DIALOG;
                            dlg_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        item_sel_d = (win_d == WIN_TEXT) ? item_d : {2'b00, dlg_d};
    end

    // Navigation state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q       <= WIN_DIALOG;
            item_q      <= ITEM_NONE;
            dlg_q       <= 1'b0;
            item_sel_q  <= ITEM_NONE;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 3'd0;
        end else begin
            win_q       <= win_d;
            item_q      <= item_d;
            dlg_q       <= dlg_d;
            item_sel_q  <= item_sel_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

    assign item_selector   = item_sel_q;
    assign window_selector = win_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_code        = cmd_code_q;

endmodule

// File: tb/tb_text_menu_ctrl.sv
// Directed bench for text_menu_ctrl: each step drives a scan-code sequence,
// pushes the expected outputs, and pops/compares them at the output latency.
module tb_text_menu_ctrl;

    typedef struct packed {
        logic [2:0] item;
        logic       win;
        logic       cv;
        logic [2:0] code;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       scan_done_tick;
    logic [7:0] scan_code;
    logic [2:0] item_selector;
    logic       window_selector;
    logic       cmd_valid;
    logic [2:0] cmd_code;

    int   tests_run;
    int   fails;
    exp_t sb_q[$];
    exp_t prev;

    text_menu_ctrl #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .scan_done_tick (scan_done_tick),
        .scan_code      (scan_code),
        .item_selector  (item_selector),
        .window_selector(window_selector),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {item_selector, window_selector, cmd_valid, cmd_code};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        tests_run++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s observed item=%0d win=%0d cv=%0d code=%0d expected item=%0d win=%0d cv=%0d code=%0d",
                   tag, got[7:5], got[4], got[3], got[2:0], want[7:5], want[4], want[3], want[2:0]);
        end
    endtask

    // Called at a falling edge; the tick is high for exactly one cycle
    task automatic put_byte(input logic [7:0] b);
        scan_done_tick = 1'b1;
        scan_code      = b;
        @(negedge clk);
        scan_done_tick = 1'b0;
        scan_code      = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive n bytes (gap idle cycles after the first), then check latency,
    // the expected update, and that cmd_valid drops after one cycle.
    task automatic step(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int n, input int gap,
                        input logic [2:0] e_item, input logic e_win,
                        input logic e_cv, input logic [2:0] e_code);
        exp_t e;
        e.item = e_item;
        e.win  = e_win;
        e.cv   = e_cv;
        e.code = e_code;
        sb_q.push_back(e);
        put_byte(b0);
        if (n > 1) begin
            idle(gap);
            put_byte(b1);
        end
        if (n > 2) begin
            put_byte(b2);
        end
        // One cycle after the final tick nothing may have moved yet
        chk({tag, "_hold"}, obs(), {prev.item, prev.win, 1'b0, prev.code});
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, "_upd"}, obs(), e);
        $display("[TB] %s: item=%0d win=%0d cmd_valid=%0d cmd_code=%0d",
                 tag, item_selector, window_selector, cmd_valid, cmd_code);
        @(negedge clk);
        chk({tag, "_after"}, obs(), {e.item, e.win, 1'b0, e.code});
        prev    = e;
        prev.cv = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        fails          = 0;
        reset          = 1'b1;
        scan_done_tick = 1'b0;
        scan_code      = 8'h00;
        prev           = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset", obs(), 8'h00);
        $display("[TB] reset: item=%0d win=%0d cmd_valid=%0d cmd_code=%0d",
                 item_selector, window_selector, cmd_valid, cmd_code);

        // Dialog Enter on item 0 opens the editor, Esc enters the menu
        step("enter_dialog0", 8'h5A, 8'h00, 8'h00, 1, 0, 3'd0, 1'b1, 1'b0, 3'd0);
        step("esc_to_menu",   8'h76, 8'h00, 8'h00, 1, 0, 3'd1, 1'b1, 1'b0, 3'd0);
        step("left_wrap",     8'hE0, 8'h6B, 8'h00, 2, 0, 3'd6, 1'b1, 1'b0, 3'd0);
        step("right_wrap",    8'hE0, 8'h74, 8'h00, 2, 0, 3'd1, 1'b1, 1'b0, 3'd0);
        step("left_a",        8'hE0, 8'h6B, 8'h00, 2, 0, 3'd6, 1'b1, 1'b0, 3'd0);
        step("left_b",        8'hE0, 8'h6B, 8'h00, 2, 0, 3'd5, 1'b1, 1'b0, 3'd0);
        step("ext_break",     8'hE0, 8'hF0, 8'h74, 3, 0, 3'd5, 1'b1, 1'b0, 3'd0);
        step("enter_break",   8'hF0, 8'h5A, 8'h00, 2, 0, 3'd5, 1'b1, 1'b0, 3'd0);
        step("up_ignored",    8'hE0, 8'h75, 8'h00, 2, 0, 3'd5, 1'b1, 1'b0, 3'd0);
        step("down_ignored",  8'hE0, 8'h72, 8'h00, 2, 0, 3'd5, 1'b1, 1'b0, 3'd0);
        step("keypad_right",  8'h74, 8'h00, 8'h00, 1, 0, 3'd5, 1'b1, 1'b0, 3'd0);
        step("right_6",       8'hE0, 8'h74, 8'h00, 2, 0, 3'd6, 1'b1, 1'b0, 3'd0);
        step("right_1",       8'hE0, 8'h74, 8'h00, 2, 0, 3'd1, 1'b1, 1'b0, 3'd0);
        step("right_2",       8'hE0, 8'h74, 8'h00, 2, 0, 3'd2, 1'b1, 1'b0, 3'd0);
        step("enter_save",    8'h5A, 8'h00, 8'h00, 1, 0, 3'd0, 1'b1, 1'b1, 3'd2);
        step("editing_arrow", 8'hE0, 8'h74, 8'h00, 2, 0, 3'd0, 1'b1, 1'b0, 3'd2);
        step("esc_menu_2",    8'h76, 8'h00, 8'h00, 1, 0, 3'd1, 1'b1, 1'b0, 3'd2);
        step("right_to_2",    8'hE0, 8'h74, 8'h00, 2, 0, 3'd2, 1'b1, 1'b0, 3'd2);
        step("right_to_3",    8'hE0, 8'h74, 8'h00, 2, 0, 3'd3, 1'b1, 1'b0, 3'd2);
        step("enter_exit",    8'h5A, 8'h00, 8'h00, 1, 0, 3'd0, 1'b0, 1'b1, 3'd3);

        // Main dialog
        step("dlg_esc",       8'h76, 8'h00, 8'h00, 1, 0, 3'd0, 1'b0, 1'b0, 3'd3);
        step("dlg_down",      8'hE0, 8'h72, 8'h00, 2, 0, 3'd1, 1'b0, 1'b0, 3'd3);
        step("dlg_enter_exit", 8'h5A, 8'h00, 8'h00, 1, 0, 3'd1, 1'b0, 1'b1, 3'd7);
        step("dlg_up",        8'hE0, 8'h75, 8'h00, 2, 0, 3'd0, 1'b0, 1'b0, 3'd7);
        step("dlg_enter_ed",  8'h5A, 8'h00, 8'h00, 1, 0, 3'd0, 1'b1, 1'b0, 3'd7);
        step("esc_menu_3",    8'h76, 8'h00, 8'h00, 1, 0, 3'd1, 1'b1, 1'b0, 3'd7);

        // Prefix timeout (TIMEOUT_CYCLES = 16)
        step("timeout_16",    8'hE0, 8'h6B, 8'h00, 2, 16, 3'd1, 1'b1, 1'b0, 3'd7);
        step("gap_14",        8'hE0, 8'h6B, 8'h00, 2, 14, 3'd6, 1'b1, 1'b0, 3'd7);
        step("back_to_1",     8'hE0, 8'h74, 8'h00, 2, 0, 3'd1, 1'b1, 1'b0, 3'd7);
        step("gap_15_edge",   8'hE0, 8'h6B, 8'h00, 2, 15, 3'd6, 1'b1, 1'b0, 3'd7);
        step("back_to_1b",    8'hE0, 8'h74, 8'h00, 2, 0, 3'd1, 1'b1, 1'b0, 3'd7);

        // Reset right after a prefix byte
        put_byte(8'hE0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset", obs(), 8'h00);
        $display("[TB] mid_reset: item=%0d win=%0d cmd_valid=%0d cmd_code=%0d",
                 item_selector, window_selector, cmd_valid, cmd_code);
        prev = '0;
        step("post_rst_74",   8'h74, 8'h00, 8'h00, 1, 0, 3'd0, 1'b0, 1'b0, 3'd0);
        step("post_rst_6b",   8'h6B, 8'h00, 8'h00, 1, 0, 3'd0, 1'b0, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
